im_loader: RTL

- Boot-time program loader; the producing end of the instruction-memory write interface (im_WE/im_DATA) the processor consumes.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word to sequential instruction-memory addresses.
- Holds the processor in reset until the load completes.

---
 rtl/im_loader_pkg.sv | 34 +++
 rtl/im_loader_if.sv | 24 ++
 rtl/im_byte_assembler.sv | 34 +++
 rtl/im_loader.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/im_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Optional trailer checksum: define IM_LOADER_CHECKSUM_EN.
package im_loader_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned IDX_W      = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_BYTE   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
`ifdef IM_LOADER_CHECKSUM_EN
        , ST_CHECK = 3'd7
`endif
    } state_e;

    // States in which the loader consumes stream bytes.
    function automatic logic takes_bytes(input state_e s);
        logic r;
        r = (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_BYTE);
`ifdef IM_LOADER_CHECKSUM_EN
        r = r || (s == ST_CHECK);
`endif
        return r;
    endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface im_loader_if #(
    parameter int unsigned ADDR_W = 8
) ();

    logic              in_START;
    logic              in_VALID;
    logic [7:0]        in_DATA;
    logic              out_READY;
    logic              im_WE;
    logic [ADDR_W-1:0] im_ADDR;
    logic [31:0]       im_DATA;

    modport master (
        output in_START, in_VALID, in_DATA,
        input  out_READY, im_WE, im_ADDR, im_DATA
    );

    modport slave (
        input  in_START, in_VALID, in_DATA,
        output out_READY, im_WE, im_ADDR, im_DATA
    );

endinterface

// File: rtl/im_byte_assembler.sv
// Big-endian 8-to-32 shift register; the first byte of a word ends up in [31:24].
module im_byte_assembler
    import im_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_c
);

    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (clear_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (byte_valid_i) begin
            word_q <= {word_q[WORD_W-BYTE_W-1:0], byte_i};
            idx_q  <= idx_q + IDX_W'(1);
        end
    end

    // High while the byte completing the current word is being accepted.
    assign word_valid_c = byte_valid_i && (idx_q == IDX_W'(WORD_BYTES - 1));
    assign word_o       = word_q;

endmodule

// File: rtl/im_loader.sv
// Boot loader: header count + big-endian words -> sequential instruction-memory writes.
// Optional trailer XOR checksum when IM_LOADER_CHECKSUM_EN is defined.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic       CLK,
    input  logic       RESET_N,
    im_loader_if.slave bus,
    output logic       out_cpu_RESET,
    output logic       out_DONE,
    output logic       out_ERROR
);

    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;
`ifdef IM_LOADER_CHECKSUM_EN
    localparam state_e ST_LAST = ST_CHECK;
`else
    localparam state_e ST_LAST = ST_DONE;
`endif

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  words_q, words_d;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] xor_q, xor_d;
`endif

    logic              accept_c;
    logic              start_c;
    logic              byte_acc_c;
    logic              word_valid_c;
    logic [CNT_W-1:0]  cnt_full_c;
    logic [WORD_W-1:0] asm_word;

    assign accept_c   = bus.in_VALID && ready_q;
    assign start_c    = bus.in_START &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
    assign byte_acc_c = accept_c && (state_q == ST_BYTE);
    assign cnt_full_c = {cnt_q[CNT_W-1:BYTE_W], bus.in_DATA};

    im_byte_assembler u_asm (
        .clk          (CLK),
        .rst_n        (RESET_N),
        .clear_i      (start_c),
        .byte_valid_i (byte_acc_c),
        .byte_i       (bus.in_DATA),
        .word_o       (asm_word),
        .word_valid_c (word_valid_c)
    );

    // Next-state and next-output logic; outputs are decoded from the next state.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        words_d = words_q;
`ifdef IM_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_c) begin
                    state_d = ST_HDR_HI;
                    addr_d  = '0;
                    cnt_d   = '0;
                    words_d = '0;
`ifdef IM_LOADER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            ST_HDR_HI: begin
                if (accept_c) begin
                    cnt_d   = {bus.in_DATA, cnt_q[BYTE_W-1:0]};
                    state_d = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (accept_c) begin
                    cnt_d = cnt_full_c;
                    if (cnt_full_c == '0) begin
                        state_d = ST_LAST;
                    end else if (32'(cnt_full_c) > MAX_WORDS) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_BYTE;
                    end
                end
            end
            ST_BYTE: begin
`ifdef IM_LOADER_CHECKSUM_EN
                if (byte_acc_c) begin
                    xor_d = xor_q ^ bus.in_DATA;
                end
`endif
                if (word_valid_c) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                words_d = words_q + CNT_W'(1);
                state_d = ((words_q + CNT_W'(1)) == cnt_q) ? ST_LAST : ST_BYTE;
            end
`ifdef IM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept_c) begin
                    state_d = (bus.in_DATA == xor_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d   = takes_bytes(state_d);
        we_d      = (state_d == ST_WRITE);
        done_d    = (state_d == ST_DONE);
        err_d     = (state_d == ST_ERROR);
        cpu_rst_d = (state_d != ST_DONE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            words_q   <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            words_q   <= words_d;
`ifdef IM_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    assign bus.out_READY = ready_q;
    assign bus.im_WE     = we_q;
    assign bus.im_ADDR   = addr_q;
    assign bus.im_DATA   = asm_word;
    assign out_cpu_RESET = cpu_rst_q;
    assign out_DONE      = done_q;
    assign out_ERROR     = err_q;

endmodule
